// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Request/response bus of the RV32I instruction encoder.
//   Request channel : req_valid/req_ready handshake carrying the decoded
//                     fields (req_kind, rd, rs1, rs2, funct3, funct7, imm).
//   Output channel  : out_valid/out_ready handshake carrying the packed word
//                     (out_instr), its byte address (out_addr) and the
//                     illegal-request flag (out_err).
// master = program builder / consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output req_valid, req_kind, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  req_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  req_valid, req_kind, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output req_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Sequential RV32I instruction encoder. Takes decoded fields over the request
// channel, range-checks the immediate, packs a 32-bit instruction word and
// emits it together with its word-aligned byte address. Illegal requests are
// replaced by NOP_WORD so the program layout is preserved.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   load_base  pulse: load the address counter from base_addr (IDLE only)
//   base_addr  new base byte address, bits [1:0] forced to 0
//   err_count  saturating count of illegal words emitted
//   bus        instr_encoder_if slave modport (request + output channels)
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [7:0]        err_count,
  instr_encoder_if.slave    bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [2:0]        r_kind;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [31:0]       r_imm;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_outAddr;
  logic [31:0]       r_outInstr;
  logic              r_outErr;
  logic [7:0]        r_errCount;

  logic              w_reqReady;
  logic              w_outValid;
  logic              w_accept;
  logic              w_legal;
  logic [31:0]       w_encoded;
  logic signed [31:0] w_immS;

  assign w_accept = w_reqReady && bus.req_valid;
  assign w_immS   = $signed(r_imm);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one word every IDLE -> CHECK -> EMIT round trip.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = CHECK;
      CHECK:   w_nextState = EMIT;
      EMIT:    if (bus.out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    w_reqReady = 1'b0;
    w_outValid = 1'b0;
    case (r_state)
      IDLE:    w_reqReady = 1'b1;
      EMIT:    w_outValid = 1'b1;
      default: ;
    endcase
  end

  // Field packing and immediate range check on the captured request.
  // Fields a format does not carry (imm for R, rs2 for I, rd for S/B,
  // funct7 outside R) are simply never placed in the word.
  always_comb begin
    w_legal   = 1'b0;
    w_encoded = 32'b0;
    case (r_kind)
      3'd0: begin
        w_legal   = 1'b1;
        w_encoded = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, OP_R};
      end
      3'd1, 3'd2: begin
        w_legal   = (w_immS >= -32'sd2048) && (w_immS <= 32'sd2047);
        w_encoded = {r_imm[11:0], r_rs1, r_funct3, r_rd,
                     (r_kind == 3'd1) ? OP_IALU : OP_LOAD};
      end
      3'd3: begin
        w_legal   = (w_immS >= -32'sd2048) && (w_immS <= 32'sd2047);
        w_encoded = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], OP_STORE};
      end
      3'd4: begin
        // Branch offsets are in bytes but always even; bit 0 is not encoded.
        w_legal   = (w_immS >= -32'sd4096) && (w_immS <= 32'sd4094) && !r_imm[0];
        w_encoded = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                     r_imm[4:1], r_imm[11], OP_BRANCH};
      end
      default: begin
        w_legal   = 1'b0;
        w_encoded = 32'b0;
      end
    endcase
  end

  // Datapath: request capture, output word registers, address counter and
  // error counter. A base load in IDLE lands before the captured request
  // reaches CHECK, so a same-cycle accept already sees the new base.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kind     <= 3'b0;
      r_rd       <= 5'b0;
      r_rs1      <= 5'b0;
      r_rs2      <= 5'b0;
      r_funct3   <= 3'b0;
      r_funct7   <= 7'b0;
      r_imm      <= 32'b0;
      r_addr     <= '0;
      r_outAddr  <= '0;
      r_outInstr <= 32'b0;
      r_outErr   <= 1'b0;
      r_errCount <= 8'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_base) begin
            r_addr <= base_addr & ~ADDR_W'(3);
          end
          if (w_accept) begin
            r_kind   <= bus.req_kind;
            r_rd     <= bus.rd;
            r_rs1    <= bus.rs1;
            r_rs2    <= bus.rs2;
            r_funct3 <= bus.funct3;
            r_funct7 <= bus.funct7;
            r_imm    <= bus.imm;
          end
        end
        CHECK: begin
          r_outInstr <= w_legal ? w_encoded : NOP_WORD;
          r_outErr   <= !w_legal;
          r_outAddr  <= r_addr;
        end
        EMIT: begin
          if (bus.out_ready) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_outErr && (r_errCount != 8'hFF)) begin
              r_errCount <= r_errCount + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_instr = r_outInstr;
  assign bus.out_addr  = r_outAddr;
  assign bus.out_err   = r_outErr;
  assign err_count     = r_errCount;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder. Two encoders run in lockstep from the
// same stimulus: one with a 32-bit address counter and one with a 4-bit
// counter, so wrap-around can be observed on the narrow one while the wide
// one keeps the plain linear address.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loadBase;
  logic [31:0] baseAddr;
  logic        reqValid;
  logic [2:0]  reqKind;
  logic [4:0]  rdS;
  logic [4:0]  rs1S;
  logic [4:0]  rs2S;
  logic [2:0]  f3S;
  logic [6:0]  f7S;
  logic [31:0] immS;
  logic        outReady;
  logic [7:0]  errCount32;
  logic [7:0]  errCount4;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic [31:0] expAddr;
  logic [7:0]  expErrCnt;

  vec_t legalVecs [10];
  vec_t illegalVecs [7];

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(32)) bus32 ();
  instr_encoder_if #(.ADDR_W(4))  bus4 ();

  assign bus32.req_valid = reqValid;
  assign bus32.req_kind  = reqKind;
  assign bus32.rd        = rdS;
  assign bus32.rs1       = rs1S;
  assign bus32.rs2       = rs2S;
  assign bus32.funct3    = f3S;
  assign bus32.funct7    = f7S;
  assign bus32.imm       = immS;
  assign bus32.out_ready = outReady;

  assign bus4.req_valid  = reqValid;
  assign bus4.req_kind   = reqKind;
  assign bus4.rd         = rdS;
  assign bus4.rs1        = rs1S;
  assign bus4.rs2        = rs2S;
  assign bus4.funct3     = f3S;
  assign bus4.funct7     = f7S;
  assign bus4.imm        = immS;
  assign bus4.out_ready  = outReady;

  instr_encoder #(.ADDR_W(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_base (loadBase),
    .base_addr (baseAddr),
    .err_count (errCount32),
    .bus       (bus32.slave)
  );

  instr_encoder #(.ADDR_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_base (loadBase),
    .base_addr (baseAddr[3:0]),
    .err_count (errCount4),
    .bus       (bus4.slave)
  );

  // Presents one request, waits for the accept edge and then for out_valid
  // (bounded). Returns with out_ready low and the word held in EMIT.
  // lat counts negedges from the request cycle to the first valid cycle.
  task automatic applyStimulus(input vec_t v, input logic lb, input logic [31:0] base,
                               output int latOut);
    @(negedge clk);
    outReady = 1'b0;
    reqKind  = v.kind;
    rdS      = v.rd;
    rs1S     = v.rs1;
    rs2S     = v.rs2;
    f3S      = v.f3;
    f7S      = v.f7;
    immS     = v.imm;
    reqValid = 1'b1;
    loadBase = lb;
    baseAddr = base;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    loadBase = 1'b0;
    latOut   = 1;
    while (bus32.out_valid !== 1'b1 && latOut < 20) begin
      @(negedge clk);
      latOut++;
    end
  endtask

  // Lets the held word go for exactly one edge.
  task automatic releaseOutput();
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    reqValid = 1'b0;
    outReady = 1'b0;
    loadBase = 1'b0;
    baseAddr = 32'h0;
    reqKind  = 3'd0;
    rdS = 5'd0; rs1S = 5'd0; rs2S = 5'd0; f3S = 3'd0; f7S = 7'd0; immS = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus32.req_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus4.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_handshake: req_ready=%b out_valid=%b req_ready4=%b, expected 1 0 1",
               bus32.req_ready, bus32.out_valid, bus4.req_ready);
    end
    checks++;
    if (bus32.out_instr !== 32'h0 || bus32.out_addr !== 32'h0 || bus32.out_err !== 1'b0 ||
        errCount32 !== 8'h0 || bus4.out_addr !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: instr=%h addr=%h err=%b cnt=%0d addr4=%h, expected all zero",
               bus32.out_instr, bus32.out_addr, bus32.out_err, errCount32, bus4.out_addr);
    end
    rst_n     = 1'b1;
    expAddr   = 32'h0;
    expErrCnt = 8'h0;
  endtask

  task automatic test_encoding();
    legalVecs[0] = '{3'd0, 5'd1,  5'd2, 5'd3, 3'd0, 7'h00, 32'h00000000, 32'h003100B3, 1'b0};
    legalVecs[1] = '{3'd0, 5'd5,  5'd6, 5'd7, 3'd0, 7'h20, 32'h00012345, 32'h407302B3, 1'b0};
    legalVecs[2] = '{3'd2, 5'd4,  5'd2, 5'd9, 3'd2, 7'h7F, 32'h00000008, 32'h00812203, 1'b0};
    legalVecs[3] = '{3'd3, 5'd31, 5'd2, 5'd5, 3'd2, 7'h00, 32'h0000000C, 32'h00512623, 1'b0};
    legalVecs[4] = '{3'd4, 5'd31, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0};
    legalVecs[5] = '{3'd4, 5'd0,  5'd3, 5'd4, 3'd1, 7'h00, 32'h00000006, 32'h00419363, 1'b0};
    legalVecs[6] = '{3'd1, 5'd1,  5'd1, 5'd0, 3'd0, 7'h00, 32'h000007FF, 32'h7FF08093, 1'b0};
    legalVecs[7] = '{3'd1, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000013, 1'b0};
    legalVecs[8] = '{3'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFF000, 32'h80208063, 1'b0};
    legalVecs[9] = '{3'd4, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h00000FFE, 32'h7E208FE3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(legalVecs[i], 1'b0, 32'h0, lat);
      checks++;
      if (bus32.out_instr !== legalVecs[i].instr || bus32.out_err !== 1'b0 ||
          bus32.out_addr !== expAddr || bus4.out_addr !== expAddr[3:0] || lat != 2) begin
        failures++;
        $display("[TB] FAIL encode[%0d]: instr=%h err=%b addr=%h addr4=%h lat=%0d, expected instr=%h err=0 addr=%h lat=2",
                 i, bus32.out_instr, bus32.out_err, bus32.out_addr, bus4.out_addr, lat,
                 legalVecs[i].instr, expAddr);
      end
      releaseOutput();
      expAddr = expAddr + 32'd4;
    end
    checks++;
    if (errCount32 !== 8'd0) begin
      failures++;
      $display("[TB] FAIL encode_errcount: err_count=%0d, expected 0", errCount32);
    end
  endtask

  task automatic test_illegal();
    illegalVecs[0] = '{3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000800, NOP, 1'b1};
    illegalVecs[1] = '{3'd4, 5'd0, 5'd3, 5'd4, 3'd1, 7'h00, 32'h00000007, NOP, 1'b1};
    illegalVecs[2] = '{3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h00000000, NOP, 1'b1};
    illegalVecs[3] = '{3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFF7FF, NOP, 1'b1};
    illegalVecs[4] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00001000, NOP, 1'b1};
    illegalVecs[5] = '{3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h00000000, NOP, 1'b1};
    illegalVecs[6] = '{3'd2, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'h80000000, NOP, 1'b1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(illegalVecs[i], 1'b0, 32'h0, lat);
      checks++;
      if (bus32.out_instr !== NOP || bus32.out_err !== 1'b1 ||
          bus32.out_addr !== expAddr || lat != 2) begin
        failures++;
        $display("[TB] FAIL illegal[%0d]: instr=%h err=%b addr=%h lat=%0d, expected instr=%h err=1 addr=%h lat=2",
                 i, bus32.out_instr, bus32.out_err, bus32.out_addr, lat, NOP, expAddr);
      end
      releaseOutput();
      expAddr   = expAddr + 32'd4;
      expErrCnt = expErrCnt + 8'd1;
      checks++;
      if (errCount32 !== expErrCnt || errCount4 !== expErrCnt) begin
        failures++;
        $display("[TB] FAIL illegal_errcount[%0d]: err_count=%0d/%0d, expected %0d",
                 i, errCount32, errCount4, expErrCnt);
      end
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(legalVecs[0], 1'b0, 32'h0, lat);
    // Scramble the request inputs to show the held word is not re-encoded.
    reqKind = 3'd4; rdS = 5'd31; rs1S = 5'd31; rs2S = 5'd31; immS = 32'hFFFFFFFE;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.req_ready !== 1'b0 ||
          bus32.out_instr !== 32'h003100B3 || bus32.out_addr !== expAddr) begin
        failures++;
        $display("[TB] FAIL backpressure_hold[%0d]: valid=%b req_ready=%b instr=%h addr=%h, expected 1 0 003100b3 %h",
                 i, bus32.out_valid, bus32.req_ready, bus32.out_instr, bus32.out_addr, expAddr);
      end
      @(negedge clk);
    end
    releaseOutput();
    expAddr = expAddr + 32'd4;
    applyStimulus(legalVecs[1], 1'b0, 32'h0, lat);
    checks++;
    if (bus32.out_instr !== 32'h407302B3 || bus32.out_addr !== expAddr) begin
      failures++;
      $display("[TB] FAIL backpressure_next: instr=%h addr=%h, expected 407302b3 %h",
               bus32.out_instr, bus32.out_addr, expAddr);
    end
    releaseOutput();
    expAddr = expAddr + 32'd4;
  endtask

  task automatic test_wrap();
    // Base 0xF loads as 0xC (low bits dropped) and applies to this same word.
    applyStimulus(legalVecs[0], 1'b1, 32'h0000000F, lat);
    expAddr = 32'h0000000C;
    checks++;
    if (bus32.out_addr !== expAddr || bus4.out_addr !== 4'hC) begin
      failures++;
      $display("[TB] FAIL wrap_base: addr=%h addr4=%h, expected 0000000c c", bus32.out_addr, bus4.out_addr);
    end
    releaseOutput();
    expAddr = expAddr + 32'd4;
    applyStimulus(legalVecs[1], 1'b0, 32'h0, lat);
    checks++;
    if (bus32.out_addr !== expAddr || bus4.out_addr !== 4'h0) begin
      failures++;
      $display("[TB] FAIL wrap_rollover: addr=%h addr4=%h, expected %h 0", bus32.out_addr, bus4.out_addr, expAddr);
    end
    releaseOutput();
    expAddr = expAddr + 32'd4;
    applyStimulus(legalVecs[2], 1'b0, 32'h0, lat);
    loadBase = 1'b1;
    baseAddr = 32'h00000040;
    @(negedge clk);
    loadBase = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_addr !== expAddr) begin
      failures++;
      $display("[TB] FAIL wrap_emit_hold: valid=%b addr=%h, expected 1 %h", bus32.out_valid, bus32.out_addr, expAddr);
    end
    releaseOutput();
    expAddr = expAddr + 32'd4;
    applyStimulus(legalVecs[3], 1'b0, 32'h0, lat);
    checks++;
    if (bus32.out_addr !== expAddr || bus4.out_addr !== expAddr[3:0]) begin
      failures++;
      $display("[TB] FAIL wrap_load_ignored: addr=%h addr4=%h, expected %h %h",
               bus32.out_addr, bus4.out_addr, expAddr, expAddr[3:0]);
    end
    releaseOutput();
    expAddr = expAddr + 32'd4;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 255; i++) begin
      applyStimulus(illegalVecs[2], 1'b0, 32'h0, lat);
      releaseOutput();
      expAddr = expAddr + 32'd4;
    end
    checks++;
    if (errCount32 !== 8'd255 || errCount4 !== 8'd255) begin
      failures++;
      $display("[TB] FAIL saturate: err_count=%0d/%0d, expected 255", errCount32, errCount4);
    end
  endtask

  task automatic test_reset_emit();
    applyStimulus(legalVecs[1], 1'b0, 32'h0, lat);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.out_addr !== 32'h0 || errCount32 !== 8'd0 ||
        bus32.req_ready !== 1'b1 || bus32.out_err !== 1'b0 || bus32.out_instr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_in_emit: valid=%b addr=%h cnt=%0d req_ready=%b err=%b instr=%h, expected 0 0 0 1 0 0",
               bus32.out_valid, bus32.out_addr, errCount32, bus32.req_ready, bus32.out_err, bus32.out_instr);
    end
    rst_n     = 1'b1;
    expAddr   = 32'h0;
    expErrCnt = 8'h0;
    applyStimulus(legalVecs[0], 1'b0, 32'h0, lat);
    checks++;
    if (bus32.out_instr !== 32'h003100B3 || bus32.out_addr !== 32'h0 || bus4.out_addr !== 4'h0 || lat != 2) begin
      failures++;
      $display("[TB] FAIL after_reset: instr=%h addr=%h addr4=%h lat=%0d, expected 003100b3 0 0 2",
               bus32.out_instr, bus32.out_addr, bus4.out_addr, lat);
    end
    releaseOutput();
  endtask

  initial begin
    test_reset();
    test_encoding();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_saturate();
    test_reset_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
